// File: rtl/demux_memoria_pkg.sv
// Shared constants for the 1:2 demultiplexer with per-lane FWFT FIFOs.
// Widths, depth, derived pointer/occupancy widths and lane indices.
package demux_memoria_pkg;

   localparam int DATA_W = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 4;

   localparam int PTR_W  = $clog2(DEPTH);
   // One extra bit so a full FIFO (occupancy == DEPTH) is representable.
   localparam int OCC_W  = $clog2(DEPTH) + 1;

   localparam int LANE0  = 0;
   localparam int LANE1  = 1;

endpackage

// File: rtl/demux_memoria_if.sv
// Producer/consumer bundle for demux_memoria: one input stream, two output lanes.
// master drives the stream and pops; slave is the demultiplexer.
interface demux_memoria_if
   import demux_memoria_pkg::*;
();

   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              selector;
   logic              ready_in;

   logic [DATA_W-1:0] data_out0;
   logic              valid_out0;
   logic              pop0;
   logic [DATA_W-1:0] data_out1;
   logic              valid_out1;
   logic              pop1;

   logic [CNT_W-1:0]  count0;
   logic [CNT_W-1:0]  count1;

   modport master (
      output data_in, valid_in, selector, pop0, pop1,
      input  ready_in, data_out0, valid_out0, data_out1, valid_out1, count0, count1
   );

   modport slave (
      input  data_in, valid_in, selector, pop0, pop1,
      output ready_in, data_out0, valid_out0, data_out1, valid_out1, count0, count1
   );

endinterface

// File: rtl/demux_fifo_lane.sv
// Single-lane first-word-fall-through FIFO with a saturating pop counter.
// Head data reads 0 whenever the lane is empty.
module demux_fifo_lane
   import demux_memoria_pkg::*;
(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic              full,
   output logic              valid,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [OCC_W-1:0]  occ_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              do_push;
   logic              do_pop;

   assign full    = (occ_reg == OCC_W'(DEPTH));
   assign valid   = (occ_reg != '0);
   assign do_push = push && !full;
   assign do_pop  = pop && valid;
   assign dout    = valid ? mem[rd_ptr_reg] : '0;
   assign count   = cnt_reg;

   // Storage is left out of reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
         cnt_reg    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (cnt_reg != {CNT_W{1'b1}}) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
         occ_reg <= occ_reg + OCC_W'(do_push) - OCC_W'(do_pop);
      end
   end

endmodule

// File: rtl/demux_memoria.sv
// 1:2 demultiplexer with memory: each accepted word is steered by selector into
// one of two FWFT lane FIFOs; readiness depends only on the selected lane.
module demux_memoria
   import demux_memoria_pkg::*;
(
   input  logic           clk,
   input  logic           reset_L,
   demux_memoria_if.slave bus
);

   logic [1:0]        push_w;
   logic [1:0]        pop_w;
   logic [1:0]        full_w;
   logic [1:0]        valid_w;
   logic [DATA_W-1:0] dout_w [2];
   logic [CNT_W-1:0]  cnt_w  [2];

   assign pop_w       = {bus.pop1, bus.pop0};
   assign bus.ready_in = reset_L && !full_w[bus.selector];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign push_w[gi] = bus.valid_in && bus.ready_in && (bus.selector == 1'(gi));

         demux_fifo_lane u_lane (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (push_w[gi]),
            .din     (bus.data_in),
            .pop     (pop_w[gi]),
            .full    (full_w[gi]),
            .valid   (valid_w[gi]),
            .dout    (dout_w[gi]),
            .count   (cnt_w[gi])
         );
      end
   endgenerate

   assign bus.data_out0  = dout_w[LANE0];
   assign bus.valid_out0 = valid_w[LANE0];
   assign bus.count0     = cnt_w[LANE0];
   assign bus.data_out1  = dout_w[LANE1];
   assign bus.valid_out1 = valid_w[LANE1];
   assign bus.count1     = cnt_w[LANE1];

endmodule

// File: doc/demux_memoria.md
Name: demux_memoria

Overview:
- 1:2 demultiplexer with memory; the inverse of the team's 2:1 mux with memory.
- Takes one DATA_W-bit input stream with a valid/ready handshake and routes each accepted word, per `selector`, into one of two per-lane FIFOs.
- Each lane presents first-word-fall-through data to its consumer and keeps a saturating delivered-word counter for the bench's conductual/estructural comparison.
- Sits downstream of the mux-with-memory path and splits a merged stream back into two lanes.

Parameters:
- DATA_W, 2, width of every data word.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- CNT_W, 4, width of each delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset; clears all state immediately; release is synchronous to clk.
- data_in  input  DATA_W  input word.
- valid_in  input  1  data_in is valid this cycle.
- selector  input  1  destination lane for data_in: 0 selects lane 0, 1 selects lane 1.
- ready_in  output  1  block can accept data_in into the selected lane this cycle.
- data_out0  output  DATA_W  head word of lane 0.
- valid_out0  output  1  lane 0 is non-empty.
- pop0  input  1  lane 0 consumer takes the head word.
- data_out1  output  DATA_W  head word of lane 1.
- valid_out1  output  1  lane 1 is non-empty.
- pop1  input  1  lane 1 consumer takes the head word.
- count0  output  CNT_W  words popped from lane 0, saturating.
- count1  output  CNT_W  words popped from lane 1, saturating.

Behaviour:
- Reset (reset_L low, asynchronous):
  - Pointers, occupancies and count0/count1 go to 0.
  - valid_out0 and valid_out1 = 0; data_out0 and data_out1 = 0.
  - ready_in = 0 while reset_L is low.
  - FIFO storage contents need not be cleared.
- ready_in:
  - Combinational: ready_in = reset_L && !fullN, where N = selector.
  - Depends only on the selected lane; the other lane being full never stalls it.
- Push:
  - Occurs at posedge when valid_in && ready_in.
  - data_in is written at lane N's write pointer; the pointer increments mod DEPTH and occupancy increments.
- Output (first-word-fall-through):
  - valid_outN = (occN != 0).
  - data_outN = storage at lane N's read pointer when non-empty; 0 when empty.
- Push latency:
  - A word pushed into an empty lane at edge k is visible on data_outN/valid_outN after edge k.
  - No combinational bypass from data_in to data_out.
- Pop:
  - Occurs at posedge when popN && valid_outN.
  - Read pointer increments mod DEPTH, occupancy decrements, countN increments.
  - countN saturates at 2^CNT_W-1 (15); it does not wrap.
  - popN while the lane is empty is ignored: no pointer, occupancy or counter change.
- Boundary conditions:
  - Simultaneous push and pop on the same non-empty lane: occupancy unchanged and both pointers advance.
  - Lane full: ready_in = 0 for that lane even if popN is asserted the same cycle. No pop-to-push bypass; the push succeeds the following cycle.
  - Lane empty with push and pop in the same cycle: the pop is ignored and the push lands.
  - Pointer wrap-around: DEPTH-1 to 0; data order is preserved across the wrap.
  - selector changes between cycles: each word follows the selector value sampled at its own push edge.
  - Lanes are independent: lane 0 and lane 1 may each pop in the same cycle as a push to either lane.
  - Reset mid-operation: all stored words are discarded; after release both lanes are empty and both counters read 0.
- Data integrity: a word is never dropped or duplicated while reset_L is high. Per-lane output order equals per-lane push order.

Decomposition:
- Shared package:
  - DATA_W, DEPTH and CNT_W defaults.
  - Pointer width constant $clog2(DEPTH) and occupancy width $clog2(DEPTH)+1.
  - Lane index constants LANE0 = 0, LANE1 = 1.
- One sub-module, demux_fifo_lane:
  - Single-lane FWFT FIFO with push, pop, full, empty, head data and a saturating pop counter.
  - Instantiated twice.
  - The top contains only the ready_in/push steering logic.

Test Plan:
- Reset release, no traffic -> valid_out0 = valid_out1 = 0; data_out0 = data_out1 = 00; count0 = count1 = 0; ready_in = 1 on the first cycle after release.
- Push 01, 10, 11 with selector = 0, then 00 with selector = 1; no pops -> lane 0 head = 01; lane 1 head = 00; both valid_out = 1.
- Pop lane 0 three times -> data_out0 sequence 01, 10, 11, then valid_out0 = 0; count0 = 3; lane 1 untouched.
- Fill lane 1 with 4 words (11, 10, 01, 00):
  - -> ready_in = 0 when selector = 1 and = 1 when selector = 0.
  - pop1 and a push to lane 1 in the same cycle -> push refused.
  - Push succeeds next cycle; wrapped order is preserved.
- 20 push/pop pairs on lane 0 -> count0 stops at 15; occupancy returns to 0.
- Assert reset_L = 0 mid-stream with 2 words in each lane -> outputs immediately 0 and ready_in = 0. After release, lanes are empty and counters are 0; the next push of 10 appears first on its lane.
